// File: rtl/circle_buffer_readout_ctrl.sv
// Circular-buffer readout: after a trigger, copies PRE+1+POST frames into the readout FIFO with headers and a trailer.
// Latency: FIFO write RD_LAT cycles after each read; backpressure: FIFO_AFULL stalls reads, in-flight words still land.
module circle_buffer_readout_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int BUF_DEPTH   = 48200,
    parameter int FRAME_LEN   = 484,
    parameter int PRE_FRAMES  = 4,
    parameter int POST_FRAMES = 0,
    parameter int RD_LAT      = 2,
    parameter int HDR_POS     = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              TRIGGER,
    input  logic [15:0]       TRIGGER_CNT,
    input  logic              FRAME_END,
    input  logic              BUFFER_WREN,
    input  logic [DATA_W-1:0] BUFFER_DOUT,
    output logic [ADDR_W-1:0] BUFFER_ADDRA,
    output logic [ADDR_W-1:0] BUFFER_ADDRB,
    output logic              BUFFER_RDEN,
    input  logic              FIFO_AFULL,
    output logic              FIFO_WREN,
    output logic [DATA_W-1:0] FIFO_DIN,
    output logic              BUSY,
    output logic              OVERRUN,
    output logic [15:0]       TRIG_DROP_CNT
);
    localparam int FRAMES = PRE_FRAMES + 1 + POST_FRAMES;
    localparam int TOTAL  = FRAMES * FRAME_LEN;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [7:0] POST_LAST = 8'(POST_FRAMES - 1);

    if (TOTAL >= BUF_DEPTH) begin : g_chk_total
        $error("readout window must be smaller than the buffer");
    end
    if (FRAMES > 255) begin : g_chk_frames
        $error("frame sequence number is 8 bits wide");
    end
    if (DATA_W < 32 || RD_LAT < 1 || RD_LAT > 3 || HDR_POS >= FRAME_LEN) begin : g_chk_param
        $error("unsupported DATA_W, RD_LAT or HDR_POS");
    end

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_POST, S_LOAD, S_READ, S_DRAIN, S_TRAILER} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] wr_ptr, rd_addr, load_addr;
    logic [ADDR_W:0]   load_diff;
    logic [CNT_W-1:0]  rd_cnt;
    logic [IDX_W-1:0]  word_idx;
    logic [7:0]        seq, post_cnt;
    logic [15:0]       trig_cnt_q, drop_cnt;
    logic              overrun_q;
    logic [RD_LAT-1:0] pipe_vld, pipe_hdr;
    logic [7:0]        pipe_seq [RD_LAT];
    logic              rd_done, ovr_hit, rd_issue;
    logic [DATA_W-1:0] hdr_word, trl_word;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(BUF_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    // Start address = end_addr - TOTAL, folded back into range when it borrows.
    assign load_diff = {1'b0, wr_ptr} - (ADDR_W+1)'(TOTAL);
    assign load_addr = load_diff[ADDR_W] ? ADDR_W'(load_diff + (ADDR_W+1)'(BUF_DEPTH))
                                         : load_diff[ADDR_W-1:0];

    assign rd_done  = (rd_cnt == CNT_W'(TOTAL));
    assign ovr_hit  = (state == S_READ) && !rd_done && (wr_ptr == rd_addr);
    assign rd_issue = (state == S_READ) && !rd_done && !ovr_hit && !FIFO_AFULL;

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (TRIGGER) state_nxt = S_ARMED;
            S_ARMED:   if (FRAME_END) state_nxt = (POST_FRAMES == 0) ? S_LOAD : S_POST;
            S_POST:    if (FRAME_END && post_cnt == POST_LAST) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_READ;
            S_READ:    if (rd_done || ovr_hit) state_nxt = S_DRAIN;
            S_DRAIN:   if (pipe_vld == '0) state_nxt = S_TRAILER;
            S_TRAILER: if (!FIFO_AFULL) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        hdr_word        = '0;
        hdr_word[31:0]  = {trig_cnt_q, 8'h00, pipe_seq[RD_LAT-1]};
        trl_word        = '0;
        trl_word[31:0]  = {trig_cnt_q, 8'hA5, 7'd0, overrun_q};
    end

    always_comb begin
        BUFFER_RDEN = rd_issue;
        BUSY        = (state != S_IDLE);
        FIFO_WREN   = 1'b0;
        FIFO_DIN    = '0;
        if (pipe_vld[RD_LAT-1]) begin
            FIFO_WREN = 1'b1;
            FIFO_DIN  = pipe_hdr[RD_LAT-1] ? hdr_word : BUFFER_DOUT;
        end else if (state == S_TRAILER && !FIFO_AFULL) begin
            FIFO_WREN = 1'b1;
            FIFO_DIN  = trl_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_addr    <= '0;
            rd_cnt     <= '0;
            word_idx   <= '0;
            seq        <= '0;
            post_cnt   <= '0;
            trig_cnt_q <= '0;
            drop_cnt   <= '0;
            overrun_q  <= 1'b0;
            pipe_vld   <= '0;
            pipe_hdr   <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_seq[i] <= '0;
        end else begin
            if (BUFFER_WREN) wr_ptr <= addr_inc(wr_ptr);

            if (state == S_IDLE && TRIGGER) begin
                trig_cnt_q <= TRIGGER_CNT;
                overrun_q  <= 1'b0;
            end else if (ovr_hit) begin
                overrun_q  <= 1'b1;
            end
            if (TRIGGER && state != S_IDLE && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;

            if (state == S_ARMED)                 post_cnt <= '0;
            else if (state == S_POST && FRAME_END) post_cnt <= post_cnt + 8'd1;

            if (state == S_LOAD) begin
                rd_addr  <= load_addr;
                rd_cnt   <= '0;
                word_idx <= '0;
                seq      <= '0;
            end else if (rd_issue) begin
                rd_addr <= addr_inc(rd_addr);
                rd_cnt  <= rd_cnt + CNT_W'(1);
                if (word_idx == IDX_W'(FRAME_LEN - 1)) begin
                    word_idx <= '0;
                    seq      <= seq + 8'd1;
                end else begin
                    word_idx <= word_idx + IDX_W'(1);
                end
            end

            // Tag each read with its header flag so the word lands RD_LAT cycles later.
            pipe_vld[0] <= rd_issue;
            pipe_hdr[0] <= rd_issue && (word_idx == IDX_W'(HDR_POS));
            pipe_seq[0] <= seq;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_hdr[i] <= pipe_hdr[i-1];
                pipe_seq[i] <= pipe_seq[i-1];
            end
        end
    end

    assign BUFFER_ADDRA  = wr_ptr;
    assign BUFFER_ADDRB  = rd_addr;
    assign OVERRUN       = overrun_q;
    assign TRIG_DROP_CNT = drop_cnt;

endmodule

// File: tb/tb_circle_buffer_readout_ctrl.sv
// Directed bench for circle_buffer_readout_ctrl in a small configuration (depth 100, 8-word frames, 1 pre, 1 post).
module tb_circle_buffer_readout_ctrl;
    localparam int DEPTH = 100;
    localparam int FLEN  = 8;
    localparam int NREAD = 24;

    logic        CLK, RST_N, TRIGGER, FRAME_END, BUFFER_WREN, FIFO_AFULL;
    logic [15:0] TRIGGER_CNT, BUFFER_ADDRA, BUFFER_ADDRB, TRIG_DROP_CNT;
    logic [31:0] BUFFER_DOUT, FIFO_DIN;
    logic        BUFFER_RDEN, FIFO_WREN, BUSY, OVERRUN;

    circle_buffer_readout_ctrl #(
        .DATA_W(32), .ADDR_W(16), .BUF_DEPTH(DEPTH), .FRAME_LEN(FLEN),
        .PRE_FRAMES(1), .POST_FRAMES(1), .RD_LAT(2), .HDR_POS(2)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .TRIGGER(TRIGGER), .TRIGGER_CNT(TRIGGER_CNT),
        .FRAME_END(FRAME_END), .BUFFER_WREN(BUFFER_WREN), .BUFFER_DOUT(BUFFER_DOUT),
        .BUFFER_ADDRA(BUFFER_ADDRA), .BUFFER_ADDRB(BUFFER_ADDRB), .BUFFER_RDEN(BUFFER_RDEN),
        .FIFO_AFULL(FIFO_AFULL), .FIFO_WREN(FIFO_WREN), .FIFO_DIN(FIFO_DIN),
        .BUSY(BUSY), .OVERRUN(OVERRUN), .TRIG_DROP_CNT(TRIG_DROP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Two-cycle RAM holding data == address.
    logic [15:0] ram_p0, ram_p1;
    always @(posedge CLK) begin
        if (BUFFER_RDEN) ram_p0 <= BUFFER_ADDRB;
        ram_p1 <= ram_p0;
    end
    assign BUFFER_DOUT = {16'h0000, ram_p1};

    typedef struct {
        int          trig_addr;
        int          fe_off;
        logic [15:0] cnt;
        int          stall_at;
        int          stall_len;
        int          ndrop;
        int          exp_start;
        int          exp_reads;
        logic        exp_ovr;
        logic [15:0] exp_drop;
    } row_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          trig_addr = -1;
    int          fe_off = 0;
    logic [15:0] trig_cnt_v = 16'h0;
    logic        pulse_trig = 1'b0;
    logic        rst_n_v = 1'b0;
    int          afull_cnt = 0;
    logic        stall_armed = 1'b0;
    int          stall_at = 0, stall_len = 0;
    int          rd_seen = 0, stall_err = 0;
    logic [31:0] wq[$];
    logic [15:0] aq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, sample just before the rising edge.
    task automatic tick();
        logic fire;
        @(negedge CLK);
        RST_N       = rst_n_v;
        BUFFER_WREN = 1'b1;
        FRAME_END   = ((int'(BUFFER_ADDRA) + fe_off) % FLEN) == FLEN - 1;
        fire        = (trig_addr >= 0) && (int'(BUFFER_ADDRA) == trig_addr);
        if (fire) trig_addr = -1;
        TRIGGER     = fire || pulse_trig;
        TRIGGER_CNT = fire ? trig_cnt_v : 16'hDEAD;
        pulse_trig  = 1'b0;
        FIFO_AFULL  = (afull_cnt > 0);
        if (afull_cnt > 0) afull_cnt--;
        #3;
        if (FIFO_AFULL && BUFFER_RDEN) stall_err++;
        if (FIFO_WREN) wq.push_back(FIFO_DIN);
        if (BUFFER_RDEN) begin
            aq.push_back(BUFFER_ADDRB);
            rd_seen++;
            if (stall_armed && rd_seen == stall_at) begin
                afull_cnt   = stall_len;
                stall_armed = 1'b0;
            end
        end
    endtask

    task automatic run_row(input row_t r, input int idx);
        logic        seen = 1'b0, done = 1'b0;
        int          busy_cyc = 0, bad = 0;
        logic [31:0] exp_w, last_w;
        wq.delete(); aq.delete();
        rd_seen = 0; stall_err = 0;
        stall_at = r.stall_at; stall_len = r.stall_len; stall_armed = (r.stall_len > 0);
        fe_off = r.fe_off; trig_cnt_v = r.cnt; trig_addr = r.trig_addr;
        for (int n = 0; n < 3000 && !done; n++) begin
            tick();
            if (BUSY) begin
                seen = 1'b1;
                busy_cyc++;
                if (busy_cyc % 3 == 0 && busy_cyc / 3 <= r.ndrop) pulse_trig = 1'b1;
            end else if (seen) begin
                done = 1'b1;
            end
        end
        chk($sformatf("row%0d_complete", idx), done, 1'b1);
        chk($sformatf("row%0d_nreads", idx), aq.size(), r.exp_reads);
        for (int i = 0; i < aq.size() && i < r.exp_reads; i++)
            if (int'(aq[i]) != (r.exp_start + i) % DEPTH) bad++;
        chk($sformatf("row%0d_addr_seq_errs", idx), bad, 0);
        chk($sformatf("row%0d_nwords", idx), wq.size(), r.exp_reads + 1);
        bad = 0;
        for (int i = 0; i < wq.size() && i < r.exp_reads; i++) begin
            exp_w = (i % FLEN == 2) ? {r.cnt, 8'h00, 8'(i / FLEN)} : 32'((r.exp_start + i) % DEPTH);
            if (wq[i] !== exp_w) bad++;
        end
        chk($sformatf("row%0d_data_errs", idx), bad, 0);
        last_w = (wq.size() > 0) ? wq[wq.size()-1] : 32'hFFFF_FFFF;
        chk($sformatf("row%0d_trailer", idx), last_w, {r.cnt, 8'hA5, 7'd0, r.exp_ovr});
        chk($sformatf("row%0d_overrun", idx), OVERRUN, r.exp_ovr);
        chk($sformatf("row%0d_drop_cnt", idx), TRIG_DROP_CNT, r.exp_drop);
        chk($sformatf("row%0d_rden_in_stall", idx), stall_err, 0);
    endtask

    row_t rows[6];

    initial begin
        //          trig fe  cnt       st  len  drop start reads ovr drop
        rows[0] = '{40,  0, 16'h0012,  0,   0, 0, 32, NREAD, 1'b0, 16'd0}; // basic
        rows[1] = '{98,  6, 16'hBEEF,  0,   0, 0, 86, NREAD, 1'b0, 16'd0}; // wrap
        rows[2] = '{47,  0, 16'h0300,  0,   0, 0, 40, NREAD, 1'b0, 16'd0}; // trigger on FRAME_END
        rows[3] = '{40,  0, 16'h0044, 10,   5, 0, 32, NREAD, 1'b0, 16'd0}; // backpressure
        rows[4] = '{40,  0, 16'h0777,  2, 200, 0, 32, 2,     1'b1, 16'd0}; // overrun
        rows[5] = '{40,  0, 16'h0055,  0,   0, 3, 32, NREAD, 1'b0, 16'd3}; // drops, clears overrun

        RST_N = 1'b0; TRIGGER = 1'b0; TRIGGER_CNT = '0; FRAME_END = 1'b0;
        BUFFER_WREN = 1'b0; FIFO_AFULL = 1'b0;
        repeat (3) @(negedge CLK);
        #3;
        chk("rst_addra", BUFFER_ADDRA, 0);
        chk("rst_addrb", BUFFER_ADDRB, 0);
        chk("rst_rden", BUFFER_RDEN, 0);
        chk("rst_fifo_wren", FIFO_WREN, 0);
        chk("rst_fifo_din", FIFO_DIN, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_overrun", OVERRUN, 0);
        chk("rst_drop", TRIG_DROP_CNT, 0);
        rst_n_v = 1'b1;

        for (int r = 0; r < 6; r++) run_row(rows[r], r);

        // Reset in the middle of a readout.
        wq.delete(); aq.delete(); rd_seen = 0; stall_armed = 1'b0;
        fe_off = 0; trig_cnt_v = 16'h0ABC; trig_addr = 40;
        for (int n = 0; n < 400 && rd_seen < 5; n++) tick();
        chk("midrst_reached_read", rd_seen >= 5, 1'b1);
        rst_n_v = 1'b0;
        tick();
        rst_n_v = 1'b1;
        wq.delete();
        tick();
        chk("midrst_addra", BUFFER_ADDRA, 0);
        chk("midrst_addrb", BUFFER_ADDRB, 0);
        chk("midrst_rden", BUFFER_RDEN, 0);
        chk("midrst_fifo_wren", FIFO_WREN, 0);
        chk("midrst_fifo_din", FIFO_DIN, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_overrun", OVERRUN, 0);
        chk("midrst_drop", TRIG_DROP_CNT, 0);
        repeat (10) tick();
        chk("midrst_no_writes", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
